// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per clock, signed or unsigned per request.
// Optional macro DIVIDE_ZERO_SHORTCUT_EN: a zero divisor skips CALC and returns one cycle after accept.
`timescale 1ns/1ps
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_n,
    input  logic [WIDTH-1:0] in_d,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_r,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_div_zero,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dmag_q, dmag_d;
    logic [WIDTH-1:0] nraw_q, nraw_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [WIDTH-1:0] res_quo_q, res_quo_d;
    logic [WIDTH-1:0] res_rem_q, res_rem_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic             res_dz_q, res_dz_d;
    logic             res_valid_q, res_valid_d;

    logic             n_neg, d_neg;
    logic [WIDTH-1:0] n_mag, d_mag;
    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH:0]   diff;
    logic             ge;

    // Shifted remainder's top bit lives in rem_q[WIDTH-1]; if it is set the trial can never underflow.
    always_comb begin
        n_neg  = in_signed & in_n[WIDTH-1];
        d_neg  = in_signed & in_d[WIDTH-1];
        n_mag  = n_neg ? ({WIDTH{1'b0}} - in_n) : in_n;
        d_mag  = d_neg ? ({WIDTH{1'b0}} - in_d) : in_d;
        rem_sh = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        diff   = {1'b0, rem_sh} - {1'b0, dmag_q};
        ge     = rem_q[WIDTH-1] | ~diff[WIDTH];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dmag_d      = dmag_q;
        nraw_d      = nraw_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        dz_d        = dz_q;
        tag_d       = tag_q;
        res_quo_d   = res_quo_q;
        res_rem_d   = res_rem_q;
        res_tag_d   = res_tag_q;
        res_dz_d    = res_dz_q;
        res_valid_d = res_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rem_d   = '0;
                    quo_d   = n_mag;
                    dmag_d  = d_mag;
                    nraw_d  = in_n;
                    qneg_d  = n_neg ^ d_neg;
                    rneg_d  = n_neg;
                    dz_d    = (in_d == '0);
                    tag_d   = in_tag;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = CALC;
`ifdef DIVIDE_ZERO_SHORTCUT_EN
                    if (in_d == '0) begin
                        state_d = FIX;
                    end
`endif
                end
            end
            CALC: begin
                rem_d = ge ? diff[WIDTH-1:0] : rem_sh;
                quo_d = {quo_q[WIDTH-2:0], ge};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                if (dz_q) begin
                    res_quo_d = '1;
                    res_rem_d = nraw_q;
                end else begin
                    res_quo_d = qneg_q ? ({WIDTH{1'b0}} - quo_q) : quo_q;
                    res_rem_d = rneg_q ? ({WIDTH{1'b0}} - rem_q) : rem_q;
                end
                res_tag_d   = tag_q;
                res_dz_d    = dz_q;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dmag_q      <= '0;
            nraw_q      <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            dz_q        <= 1'b0;
            tag_q       <= '0;
            res_quo_q   <= '0;
            res_rem_q   <= '0;
            res_tag_q   <= '0;
            res_dz_q    <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dmag_q      <= dmag_d;
            nraw_q      <= nraw_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            dz_q        <= dz_d;
            tag_q       <= tag_d;
            res_quo_q   <= res_quo_d;
            res_rem_q   <= res_rem_d;
            res_tag_q   <= res_tag_d;
            res_dz_q    <= res_dz_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Gated by rstn so every output reads 0 while reset is held.
    assign in_ready     = rstn & (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign out_valid    = res_valid_q;
    assign out_q        = res_quo_q;
    assign out_r        = res_rem_q;
    assign out_tag      = res_tag_q;
    assign out_div_zero = res_dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider (WIDTH=8, TAG_W=4); expected results queued at accept,
// popped by an independent monitor on each output handshake.
`timescale 1ns/1ps
module tb_seq_divider;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic [3:0] tag;
        logic       dz;
    } exp_t;

`ifdef DIVIDE_ZERO_SHORTCUT_EN
    localparam int DZ_LAT = 1;
`else
    localparam int DZ_LAT = 9;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_signed = 1'b0;
    logic [7:0] in_n = '0;
    logic [7:0] in_d = '0;
    logic [3:0] in_tag = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_q;
    logic [7:0] out_r;
    logic [3:0] out_tag;
    logic       out_div_zero;
    logic       busy;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   rand_done = 1'b0;
    exp_t sb[$];

    seq_divider #(.WIDTH(8), .TAG_W(4)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
        .in_n(in_n), .in_d(in_d), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_tag(out_tag),
        .out_div_zero(out_div_zero), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    endtask

    // Monitor: one line per consumed result, compared against the oldest accepted request.
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            exp_t e;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_result: got q=%h r=%h tag=%h dz=%b want no result",
                         out_q, out_r, out_tag, out_div_zero);
            end else begin
                e = sb.pop_front();
                if ({out_q, out_r, out_tag, out_div_zero} !== e) begin
                    miscompares++;
                    $display("FAIL result: got q=%h r=%h tag=%h dz=%b want q=%h r=%h tag=%h dz=%b",
                             out_q, out_r, out_tag, out_div_zero, e.q, e.r, e.tag, e.dz);
                end else begin
                    $display("txn tag=%h q=%h r=%h dz=%b ok", out_tag, out_q, out_r, out_div_zero);
                end
            end
        end
    end

    function automatic exp_t model(input bit s, input logic [7:0] n, input logic [7:0] d,
                                   input logic [3:0] t);
        exp_t e;
        logic sn, sd;
        logic [7:0] an, ad, qm, rm;
        e.tag = t;
        if (d == 8'd0) begin
            e.q = 8'hFF; e.r = n; e.dz = 1'b1;
        end else begin
            sn = s & n[7];
            sd = s & d[7];
            an = sn ? (8'd0 - n) : n;
            ad = sd ? (8'd0 - d) : d;
            qm = an / ad;
            rm = an % ad;
            e.q  = (sn ^ sd) ? (8'd0 - qm) : qm;
            e.r  = sn ? (8'd0 - rm) : rm;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Offer a request and hold it until accepted; returns the cycle count of the accept edge.
    task automatic send(input bit s, input logic [7:0] n, input logic [7:0] d, input logic [3:0] tag,
                        input exp_t e, output int acc);
        bit ok = 1'b0;
        in_signed = s; in_n = n; in_d = d; in_tag = tag; in_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            miscompares++;
            $display("FAIL accept_timeout: got in_ready=0 for 300 cycles want accept of tag %h", tag);
            summary();
            $fatal(1, "accept timeout");
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int acc, output int lat);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - acc;
                break;
            end
        end
        if (lat < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL valid_timeout: got out_valid=0 for 40 cycles want out_valid=1");
        end
    endtask

    task automatic run_dir(input bit s, input logic [7:0] n, input logic [7:0] d, input logic [3:0] tag,
                           input logic [7:0] q, input logic [7:0] r, input logic dz);
        exp_t e;
        int acc, lat;
        e.q = q; e.r = r; e.tag = tag; e.dz = dz;
        send(s, n, d, tag, e, acc);
        wait_valid(acc, lat);
        chk("latency", lat, dz ? DZ_LAT : 9);
        sync();
    endtask

    initial begin
        #3000000;
        miscompares++;
        $display("FAIL watchdog: got no completion want $finish before 3ms");
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t ea, eb, ec;
        int acc, lat, rel;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_q", out_q, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_div_zero", out_div_zero, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);
        sync();

        // Directed arithmetic vectors
        run_dir(0, 8'd100, 8'd7,  4'h3, 8'd14,  8'd2,  0);
        run_dir(1, 8'hF9,  8'h02, 4'h1, 8'hFD,  8'hFF, 0);
        run_dir(1, 8'h80,  8'hFF, 4'h2, 8'h80,  8'h00, 0);
        run_dir(0, 8'hF9,  8'h02, 4'h4, 8'h7C,  8'h01, 0);
        run_dir(1, 8'h07,  8'hFE, 4'h7, 8'hFD,  8'h01, 0);
        run_dir(1, 8'hF9,  8'hFE, 4'h8, 8'h03,  8'hFF, 0);
        run_dir(0, 8'h05,  8'h09, 4'h9, 8'h00,  8'h05, 0);
        run_dir(0, 8'hFF,  8'h01, 4'hC, 8'hFF,  8'h00, 0);
        run_dir(0, 8'h80,  8'hFF, 4'hD, 8'h00,  8'h80, 0);
        run_dir(1, 8'h80,  8'h01, 4'hE, 8'h80,  8'h00, 0);

        // Divide by zero, both modes
        run_dir(0, 8'h37, 8'h00, 4'h1, 8'hFF, 8'h37, 1);
        run_dir(1, 8'h37, 8'h00, 4'h2, 8'hFF, 8'h37, 1);
        run_dir(1, 8'hC8, 8'h00, 4'h3, 8'hFF, 8'hC8, 1);

        // Backpressure with a second request held on in_valid
        out_ready = 1'b0;
        ea.q = 8'd22; ea.r = 8'd2; ea.tag = 4'hA; ea.dz = 1'b0;
        send(0, 8'd200, 8'd9, 4'hA, ea, acc);
        in_signed = 1'b1; in_n = 8'h9C; in_d = 8'h07; in_tag = 4'hB; in_valid = 1'b1;
        wait_valid(acc, lat);
        chk("bp_latency", lat, 9);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_q", out_q, 8'd22);
            chk("bp_out_r", out_r, 8'd2);
            chk("bp_out_tag", out_tag, 4'hA);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        sync();
        rel = cyc;
        out_ready = 1'b1;
        eb.q = 8'hF2; eb.r = 8'hFE; eb.tag = 4'hB; eb.dz = 1'b0;
        send(1, 8'h9C, 8'h07, 4'hB, eb, acc);
        chk("bp_accept_after_consume", acc - rel, 2);
        wait_valid(acc, lat);
        sync();

        // Reset in the middle of CALC aborts the request
        ec.q = 8'd66; ec.r = 8'd2; ec.tag = 4'h5; ec.dz = 1'b0;
        send(0, 8'd200, 8'd3, 4'h5, ec, acc);
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_q", out_q, 0);
        chk("mid_rst_out_r", out_r, 0);
        chk("mid_rst_out_tag", out_tag, 0);
        chk("mid_rst_div_zero", out_div_zero, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        repeat (12) @(negedge clk);
        chk("no_stale_valid", out_valid, 0);
        chk("no_stale_busy", busy, 0);
        sync();
        run_dir(0, 8'd77, 8'd10, 4'h6, 8'd7, 8'd7, 0);

        // Randomised traffic against the reference model, tag order enforced by the queue
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    bit s;
                    logic [7:0] n, d;
                    logic [3:0] t;
                    int idle;
                    idle = $urandom_range(0, 3);
                    repeat (idle) @(posedge clk);
                    #1;
                    s = ($urandom_range(0, 1) == 1);
                    n = 8'($urandom);
                    d = 8'($urandom);
                    if ($urandom_range(0, 15) == 0) d = 8'h00;
                    if ($urandom_range(0, 15) == 0) d = 8'hFF;
                    if ($urandom_range(0, 15) == 0) n = 8'h80;
                    t = 4'(i);
                    send(s, n, d, t, model(s, n, d, t), acc);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        out_ready = 1'b1;
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        chk("drain_empty", sb.size(), 0);

        summary();
        $finish;
    end

endmodule
